// File: rtl/riscv_pkg.sv
// riscv_pkg: encodings shared by the decoder and the writeback stage.
//   result_src_e : writeback result select (ALU / load data / PC+4 / none)
//   wb_write_en  : final register-file write qualification
package riscv_pkg;

  localparam int unsigned RESULT_SRC_W = 2;

  typedef enum logic [RESULT_SRC_W-1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_NONE = 2'b11
  } result_src_e;

  // A write only happens for a real instruction that targets a non-x0
  // register with a defined result source.
  function automatic logic wb_write_en(input logic        valid,
                                       input logic        reg_write,
                                       input logic        rd_nonzero,
                                       input result_src_e src);
    return valid & reg_write & rd_nonzero & (src != RES_NONE);
  endfunction

endpackage

// File: rtl/result_mux.sv
// result_mux: combinational writeback result selector.
//   src    : result select (riscv_pkg::result_src_e)
//   alu    : ALU result
//   mem    : load data, already extended
//   pc4    : PC+4 for link instructions
//   result : selected value, zero for the reserved encoding
module result_mux
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  result_src_e           src,
  input  logic [DATA_WIDTH-1:0] alu,
  input  logic [DATA_WIDTH-1:0] mem,
  input  logic [DATA_WIDTH-1:0] pc4,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (src)
      RES_ALU: result = alu;
      RES_MEM: result = mem;
      RES_PC4: result = pc4;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/tract_w.sv
// tract_w: MEM/WB pipeline register, writeback result select and
// retired-instruction counter.
//   clk, rst          : clock, asynchronous active-high reset
//   stall_w, flush_w  : hold / bubble the MEM/WB slot (flush wins)
//   valid_m .. rd_m   : memory-stage instruction fields
//   reg_write_w, rd_w : register-file write enable and index
//   result_w          : register-file write data / forwarding source
//   instret           : 64-bit retired-instruction count (wraps)
// Optional (macro TRACT_W_FWD_HOLD_EN): fwd_valid, fwd_rd, fwd_data hold
// the write committed one cycle earlier for write-then-read hazards.
module tract_w
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_w,
  input  logic                      flush_w,
  input  logic                      valid_m,
  input  logic                      reg_write_m,
  input  logic [1:0]                result_src_m,
  input  logic [DATA_WIDTH-1:0]     alu_result_m,
  input  logic [DATA_WIDTH-1:0]     read_part_data_m,
  input  logic [DATA_WIDTH-1:0]     pc_plus4_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  output logic                      reg_write_w,
  output logic [REG_ADDR_WIDTH-1:0] rd_w,
  output logic [DATA_WIDTH-1:0]     result_w,
  output logic [63:0]               instret
`ifdef TRACT_W_FWD_HOLD_EN
  ,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data
`endif
);

  logic                      valid_q;
  logic                      reg_write_q;
  result_src_e               src_q;
  logic [DATA_WIDTH-1:0]     alu_q;
  logic [DATA_WIDTH-1:0]     mem_q;
  logic [DATA_WIDTH-1:0]     pc4_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  // The writeback slot is vacated on any edge it is not held; a flush
  // replaces the incoming entry but still lets the current one retire.
  logic advance;
  assign advance = flush_w | ~stall_w;

  // MEM/WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      src_q       <= RES_ALU;
      alu_q       <= '0;
      mem_q       <= '0;
      pc4_q       <= '0;
      rd_q        <= '0;
    end else if (flush_w) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      src_q       <= RES_ALU;
      alu_q       <= '0;
      mem_q       <= '0;
      pc4_q       <= '0;
      rd_q        <= '0;
    end else if (!stall_w) begin
      valid_q     <= valid_m;
      reg_write_q <= reg_write_m;
      src_q       <= result_src_e'(result_src_m);
      alu_q       <= alu_result_m;
      mem_q       <= read_part_data_m;
      pc4_q       <= pc_plus4_m;
      rd_q        <= rd_m;
    end
  end

  // Retirement counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= 64'd0;
    end else if (valid_q && advance) begin
      instret <= instret + 64'd1;
    end
  end

  assign reg_write_w = wb_write_en(valid_q, reg_write_q, (rd_q != '0), src_q);
  assign rd_w        = rd_q;

  result_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_result_mux (
    .src   (src_q),
    .alu   (alu_q),
    .mem   (mem_q),
    .pc4   (pc4_q),
    .result(result_w)
  );

`ifdef TRACT_W_FWD_HOLD_EN
  // Hold the last committed write for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_rd    <= '0;
      fwd_data  <= '0;
    end else if (advance) begin
      fwd_valid <= reg_write_w;
      fwd_rd    <= rd_w;
      fwd_data  <= result_w;
    end
  end
`endif

endmodule

// File: tb/tb_tract_w.sv
// tb_tract_w: self-checking bench for tract_w with a scoreboard of
// expected writeback outputs and a reference retirement count.
module tb_tract_w;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_w, flush_w, valid_m, reg_write_m;
  logic [1:0]    result_src_m;
  logic [DW-1:0] alu_result_m, read_part_data_m, pc_plus4_m;
  logic [AW-1:0] rd_m;
  logic          reg_write_w;
  logic [AW-1:0] rd_w;
  logic [DW-1:0] result_w;
  logic [63:0]   instret;
`ifdef TRACT_W_FWD_HOLD_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
`endif

  tract_w #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_w         (stall_w),
    .flush_w         (flush_w),
    .valid_m         (valid_m),
    .reg_write_m     (reg_write_m),
    .result_src_m    (result_src_m),
    .alu_result_m    (alu_result_m),
    .read_part_data_m(read_part_data_m),
    .pc_plus4_m      (pc_plus4_m),
    .rd_m            (rd_m),
    .reg_write_w     (reg_write_w),
    .rd_w            (rd_w),
    .result_w        (result_w),
    .instret         (instret)
`ifdef TRACT_W_FWD_HOLD_EN
    ,
    .fwd_valid       (fwd_valid),
    .fwd_rd          (fwd_rd),
    .fwd_data        (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic [AW-1:0] rd;
    logic [DW-1:0] res;
    bit            chk_data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  logic        mdl_valid;
  logic [63:0] exp_instret;
  int          total = 0;
  int          bad = 0;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    mdl_valid    = 1'b0;
    exp_instret  = 64'd0;
    cur.rw       = 1'b0;
    cur.rd       = '0;
    cur.res      = '0;
    cur.chk_data = 1'b1;
    sbq.delete();
  endtask

  task automatic idle_inputs();
    stall_w = 0; flush_w = 0; valid_m = 0; reg_write_m = 0;
    result_src_m = 2'b00; alu_result_m = '0; read_part_data_m = '0;
    pc_plus4_m = '0; rd_m = '0;
  endtask

  // One clock: drive, predict, then compare after the edge.
  task automatic step(input logic s, input logic f, input logic v, input logic w,
                      input logic [1:0] src, input logic [DW-1:0] a,
                      input logic [DW-1:0] m, input logic [DW-1:0] p,
                      input logic [AW-1:0] rd, input string name);
    exp_t e;
    stall_w = s; flush_w = f; valid_m = v; reg_write_m = w;
    result_src_m = src; alu_result_m = a; read_part_data_m = m;
    pc_plus4_m = p; rd_m = rd;
    if ((f || !s) && mdl_valid) exp_instret = exp_instret + 64'd1;
    if (f) begin
      mdl_valid = 1'b0; cur.rw = 1'b0; cur.chk_data = 1'b0;
    end else if (!s) begin
      mdl_valid    = v;
      cur.rd       = rd;
      cur.res      = (src == 2'd0) ? a : (src == 2'd1) ? m : (src == 2'd2) ? p : '0;
      cur.rw       = v & w & (rd != '0) & (src != 2'd3);
      cur.chk_data = 1'b1;
    end
    sbq.push_back(cur);
    @(posedge clk); #1;
    e = sbq.pop_front();
    total++;
    if (reg_write_w !== e.rw) begin
      bad++; $display("FAIL %s reg_write_w got %0b want %0b", name, reg_write_w, e.rw);
    end
    if (e.chk_data) begin
      total++;
      if (rd_w !== e.rd) begin
        bad++; $display("FAIL %s rd_w got %0d want %0d", name, rd_w, e.rd);
      end
      total++;
      if (result_w !== e.res) begin
        bad++; $display("FAIL %s result_w got %h want %h", name, result_w, e.res);
      end
    end
    total++;
    if (instret !== exp_instret) begin
      bad++; $display("FAIL %s instret got %0d want %0d", name, instret, exp_instret);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    total++;
    if (reg_write_w !== 1'b0 || rd_w !== '0 || result_w !== '0 || instret !== 64'd0) begin
      bad++;
      $display("FAIL %s outputs got rw=%0b rd=%0d res=%h cnt=%0d want all 0",
               name, reg_write_w, rd_w, result_w, instret);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    valid_m = 1; reg_write_m = 1; rd_m = 5'd5; alu_result_m = 32'h1234;
    #12;
    check_zero_outputs("reset_hold");
    idle_inputs();
    #4;                       // t=16, one unit after an edge
    rst = 1'b0;
    model_reset();
    check_zero_outputs("reset_release");
  endtask

  task automatic test_alu();
    step(0, 0, 1, 1, 2'b00, 32'h0000_0010, 32'h0, 32'h0, 5'd5, "alu_rd5");
    total++;
    if (instret !== 64'd0) begin
      bad++; $display("FAIL alu_first_cnt instret got %0d want 0", instret);
    end
    step(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, "alu_retire");
    total++;
    if (instret !== 64'd1) begin
      bad++; $display("FAIL alu_instret got %0d want 1", instret);
    end
  endtask

  task automatic test_load_rd0();
    step(0, 0, 1, 1, 2'b01, 32'h7, 32'hFFFF_FF80, 32'h8, 5'd0, "load_rd0");
    step(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, "load_rd0_retire");
  endtask

  task automatic test_stall();
    step(0, 0, 1, 1, 2'b10, 32'h1, 32'h2, 32'h104, 5'd3, "stall_load");
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 1, 2'b00, 32'hDEAD, 32'hBEEF, 32'h200, 5'd9, "stall_hold");
    step(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, "stall_release");
  endtask

  task automatic test_flush_counts();
    step(0, 0, 1, 1, 2'b00, 32'h33, 32'h0, 32'h0, 5'd4, "flush_load");
    step(0, 1, 1, 1, 2'b00, 32'h44, 32'h0, 32'h0, 5'd6, "flush_retire");
    step(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, "flush_bubble");
  endtask

  task automatic test_stall_flush();
    step(0, 0, 1, 1, 2'b00, 32'h77, 32'h0, 32'h0, 5'd8, "sf_load");
    step(1, 1, 1, 1, 2'b00, 32'h88, 32'h0, 32'h0, 5'd10, "sf_edge");
    step(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, "sf_after");
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd1, "wrap_load");
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    step(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, "wrap_retire");
    total++;
    if (instret !== 64'd0) begin
      bad++; $display("FAIL wrap_zero instret got %h want 0", instret);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, 1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd9, "mid_load");
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("mid_async");
    idle_inputs();
    @(posedge clk); #1;
    check_zero_outputs("mid_held");
    rst = 1'b0;
    model_reset();
    check_zero_outputs("mid_release");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] r;
    for (int i = 0; i < 40; i++) begin
      r = AW'($urandom_range(0, 31));
      step(($urandom % 4) == 0, ($urandom % 7) == 0, ($urandom % 5) != 0,
           ($urandom % 3) != 0, 2'($urandom % 4), $urandom, $urandom, $urandom,
           r, "b2b");
    end
  endtask

`ifdef TRACT_W_FWD_HOLD_EN
  task automatic test_fwd();
    step(0, 0, 1, 1, 2'b00, 32'hA5, 32'h0, 32'h0, 5'd7, "fwd_write");
    step(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, "fwd_next");
    total++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 32'hA5) begin
      bad++;
      $display("FAIL fwd_hold got v=%0b rd=%0d d=%h want v=1 rd=7 d=a5",
               fwd_valid, fwd_rd, fwd_data);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_alu();
    test_load_rd0();
    test_stall();
    test_flush_counts();
    test_stall_flush();
    test_wrap();
    test_back_to_back();
`ifdef TRACT_W_FWD_HOLD_EN
    test_fwd();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
